// File: rtl/sonar_distance_filter.sv
// Range/spike rejection and DEPTH-sample moving average for echo distance samples.
// The average is registered one edge after the accept that leaves the window full.
module sonar_distance_filter #(
    parameter int DW          = 32,
    parameter int DEPTH_LOG2  = 3,
    parameter int MIN_VALID   = 6,
    parameter int MAX_VALID   = 765,
    parameter int MAX_STEP    = 50,
    parameter int SPIKE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_valid,
    input  logic [DW-1:0]         sample,
    input  logic                  clear,
    output logic [DW-1:0]         avg,
    output logic                  avg_valid,
    output logic                  filled,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  rejected,
    output logic [15:0]           reject_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SW    = DW + DEPTH_LOG2;
    localparam int SRW   = $clog2(SPIKE_LIMIT + 1);

    localparam logic [DW-1:0]       MIN_V     = DW'(MIN_VALID);
    localparam logic [DW-1:0]       MAX_V     = DW'(MAX_VALID);
    localparam logic [DW-1:0]       STEP_V    = DW'(MAX_STEP);
    localparam logic [SRW-1:0]      SPIKE_LIM = SRW'(SPIKE_LIMIT);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {S_FILL, S_TRACK} state_t;

    state_t                r_state;
    logic [DW-1:0]         r_buf [DEPTH];
    logic [SW-1:0]         r_sum;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [SRW-1:0]        r_spike_run;
    logic [DW-1:0]         r_avg;
    logic                  r_avg_valid;
    logic                  r_avg_pend;
    logic                  r_filled;
    logic                  r_rejected;
    logic [15:0]           r_reject_count;

    logic                  w_in_range;
    logic [DW-1:0]         w_diff;
    logic                  w_spike;
    logic                  w_force;
    logic                  w_accept;
    logic                  w_reject;
    logic                  w_flush;
    logic [DW-1:0]         w_old;
    logic [SW-1:0]         w_sum_next;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  w_full_next;

    always_comb begin
        w_in_range   = (sample >= MIN_V) && (sample <= MAX_V);
        w_diff       = (sample > r_avg) ? (sample - r_avg) : (r_avg - sample);
        w_spike      = (r_state == S_TRACK) && (w_diff > STEP_V);
        w_force      = (r_spike_run >= SPIKE_LIM);
        w_accept     = sample_valid && w_in_range && (!w_spike || w_force);
        w_reject     = sample_valid && !w_accept;
        w_flush      = reset || clear;
        w_old        = r_buf[r_wr_ptr];
        w_sum_next   = r_sum - SW'(w_old) + SW'(sample);
        w_count_next = (r_count == DEPTH_CNT) ? r_count : r_count + 1'b1;
        w_full_next  = (w_count_next == DEPTH_CNT);
    end

    // NOTE: the window storage is cleared on flush because vacated slots must
    // read as zero for the running sum to stay exact while filling.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else if (w_accept) begin
            r_buf[r_wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state     <= S_FILL;
            r_sum       <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_spike_run <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_avg_pend  <= 1'b0;
            r_filled    <= 1'b0;
            r_rejected  <= 1'b0;
        end else begin
            r_avg_valid <= r_avg_pend;
            r_avg_pend  <= 1'b0;
            r_rejected  <= w_reject;
            if (r_avg_pend) r_avg <= DW'(r_sum >> DEPTH_LOG2);
            if (w_accept) begin
                r_sum       <= w_sum_next;
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_count     <= w_count_next;
                r_spike_run <= '0;
                r_avg_pend  <= w_full_next;
                if (r_state == S_FILL && w_full_next) begin
                    r_state  <= S_TRACK;
                    r_filled <= 1'b1;
                end
            end else if (w_reject && w_in_range) begin
                // In-range reject only happens for an unforced spike.
                r_spike_run <= r_spike_run + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reject_count <= '0;
        end else if (!clear && w_reject && r_reject_count != 16'hFFFF) begin
            r_reject_count <= r_reject_count + 16'd1;
        end
    end

    assign avg          = r_avg;
    assign avg_valid    = r_avg_valid;
    assign filled       = r_filled;
    assign count        = r_count;
    assign rejected     = r_rejected;
    assign reject_count = r_reject_count;

endmodule

// File: tb/tb_sonar_distance_filter.sv
// Bench for sonar_distance_filter: directed scenarios plus random traffic against
// a queue-based window model of the filter.
module tb_sonar_distance_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [31:0] sample = '0;
    logic        clear = 1'b0;
    logic [31:0] avg;
    logic        avg_valid;
    logic        filled;
    logic [3:0]  count;
    logic        rejected;
    logic [15:0] reject_count;

    sonar_distance_filter dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .clear        (clear),
        .avg          (avg),
        .avg_valid    (avg_valid),
        .filled       (filled),
        .count        (count),
        .rejected     (rejected),
        .reject_count (reject_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: the window is simply the last eight accepted samples.
    int unsigned win[$];
    logic [31:0] m_avg = '0;
    logic        m_avg_valid = 1'b0;
    logic        m_filled = 1'b0;
    logic        m_rejected = 1'b0;
    logic        m_pend = 1'b0;
    logic [15:0] m_rc = '0;
    int          m_spike = 0;

    logic [54:0] dut_vec;
    assign dut_vec = {avg, avg_valid, filled, count, rejected, reject_count};

    function automatic logic [54:0] exp_vec();
        return {m_avg, m_avg_valid, m_filled, 4'(win.size()), m_rejected, m_rc};
    endfunction

    task automatic model_edge(input logic v, input logic [31:0] s, input logic clr, input logic rst);
        int unsigned total;
        int unsigned d;
        logic [31:0] old_avg;
        bit acc;
        if (rst || clr) begin
            win.delete();
            m_avg = '0; m_avg_valid = 1'b0; m_filled = 1'b0;
            m_rejected = 1'b0; m_pend = 1'b0; m_spike = 0;
            if (rst) m_rc = '0;
            return;
        end
        old_avg     = m_avg;
        m_avg_valid = m_pend;
        if (m_pend) begin
            total = 0;
            foreach (win[i]) total += win[i];
            m_avg = total / 8;
        end
        m_pend     = 1'b0;
        m_rejected = 1'b0;
        if (v) begin
            acc = (s >= 6) && (s <= 765);
            if (acc && m_filled) begin
                d = (s > old_avg) ? s - old_avg : old_avg - s;
                if (d > 50 && m_spike < 3) begin
                    acc = 0;
                    m_spike++;
                end
            end
            if (acc) begin
                win.push_back(s);
                if (win.size() > 8) void'(win.pop_front());
                m_spike = 0;
                if (win.size() == 8) begin
                    m_filled = 1'b1;
                    m_pend   = 1'b1;
                end
            end else begin
                m_rejected = 1'b1;
                if (m_rc != 16'hFFFF) m_rc++;
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] s, input logic clr = 1'b0, input logic rst = 1'b0);
        @(negedge clk);
        sample_valid = v; sample = s; clear = clr; reset = rst;
        @(posedge clk);
        model_edge(v, s, clr, rst);
        #1;
        sample_valid = 1'b0; clear = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b0, '0, 1'b0, 1'b1);
        n_total++;
        if (dut_vec !== 55'd0) begin
            n_bad++;
            $display("FAIL reset_state got=%h want=0", dut_vec);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'd100);
            n_total++;
            if (count !== 4'(i + 1) || filled !== (i == 7) || avg_valid !== 1'b0 || rejected !== 1'b0) begin
                n_bad++;
                $display("FAIL fill[%0d] count=%0d filled=%b avg_valid=%b rejected=%b want count=%0d filled=%b",
                         i, count, filled, avg_valid, rejected, i + 1, i == 7);
            end
        end
        step(1'b0, '0);
        n_total++;
        if (avg_valid !== 1'b1 || avg !== 32'd100) begin
            n_bad++;
            $display("FAIL fill_avg avg_valid=%b avg=%0d want 1/100", avg_valid, avg);
        end
        step(1'b0, '0);
        n_total++;
        if (avg_valid !== 1'b0 || avg !== 32'd100 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL fill_hold got=%h want=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_spike();
        step(1'b1, 32'd180);
        n_total++;
        if (rejected !== 1'b1 || reject_count !== 16'd1 || avg !== 32'd100) begin
            n_bad++;
            $display("FAIL spike_reject rejected=%b rc=%0d avg=%0d want 1/1/100", rejected, reject_count, avg);
        end
        step(1'b1, 32'd140);
        step(1'b0, '0);
        n_total++;
        if (avg_valid !== 1'b1 || avg !== 32'd105) begin
            n_bad++;
            $display("FAIL spike_small avg_valid=%b avg=%0d want 1/105", avg_valid, avg);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'd300);
            n_total++;
            if (rejected !== (i < 3) || reject_count !== 16'(2 + (i < 3 ? i : 2))) begin
                n_bad++;
                $display("FAIL spike_run[%0d] rejected=%b rc=%0d want %b/%0d",
                         i, rejected, reject_count, i < 3, 2 + (i < 3 ? i : 2));
            end
        end
        step(1'b0, '0);
        n_total++;
        if (avg_valid !== 1'b1 || avg !== 32'd130 || dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL spike_force avg_valid=%b avg=%0d want 1/130", avg_valid, avg);
        end
    endtask

    task automatic test_range();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 32'd5);
        step(1'b1, 32'd766);
        n_total++;
        if (count !== 4'd0 || reject_count !== 16'd2 || rejected !== 1'b1) begin
            n_bad++;
            $display("FAIL range_reject count=%0d rc=%0d rejected=%b want 0/2/1", count, reject_count, rejected);
        end
        step(1'b1, 32'd6);
        step(1'b1, 32'd765);
        n_total++;
        if (count !== 4'd2 || reject_count !== 16'd2 || rejected !== 1'b0) begin
            n_bad++;
            $display("FAIL range_edges count=%0d rc=%0d rejected=%b want 2/2/0", count, reject_count, rejected);
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) step(1'b1, 32'd100);
        n_total++;
        if (count !== 4'd5) begin
            n_bad++;
            $display("FAIL clear_pre count=%0d want 5", count);
        end
        step(1'b1, 32'd100, 1'b1);
        n_total++;
        if (count !== 4'd0 || filled !== 1'b0 || reject_count !== 16'd2 || rejected !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_state count=%0d filled=%b rc=%0d rejected=%b want 0/0/2/0",
                     count, filled, reject_count, rejected);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 32'd200);
        step(1'b0, '0);
        n_total++;
        if (avg_valid !== 1'b1 || avg !== 32'd200 || filled !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_refill avg_valid=%b avg=%0d filled=%b want 1/200/1", avg_valid, avg, filled);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        force dut.r_reject_count = 16'hFFFE;
        #1;
        release dut.r_reject_count;
        m_rc = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'd3);
            n_total++;
            if (reject_count !== 16'hFFFF || rejected !== 1'b1) begin
                n_bad++;
                $display("FAIL saturate[%0d] rc=%h rejected=%b want ffff/1", i, reject_count, rejected);
            end
        end
    endtask

    task automatic test_reset_cancel();
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 32'd200);
        step(1'b0, '0, 1'b0, 1'b1);
        n_total++;
        if (dut_vec !== 55'd0) begin
            n_bad++;
            $display("FAIL reset_cancel got=%h want=0", dut_vec);
        end
        step(1'b0, '0);
        n_total++;
        if (dut_vec !== 55'd0) begin
            n_bad++;
            $display("FAIL reset_cancel_next got=%h want=0", dut_vec);
        end
    endtask

    task automatic test_random();
        int r;
        int base;
        int s;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                s = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(766, 2000));
            end else if (r < 30) begin
                s = int'($urandom_range(6, 765));
            end else begin
                base = (m_avg == 0) ? 300 : int'(m_avg);
                s = base + int'($urandom_range(0, 140)) - 70;
                if (s < 6) s = 6;
                if (s > 765) s = 765;
            end
            r = int'($urandom_range(0, 99));
            step($urandom_range(0, 3) != 0, 32'(s), r < 2, r == 2);
            n_total++;
            if (dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d] got=%h want=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_spike();
        test_range();
        test_clear();
        test_saturate();
        test_reset_cancel();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
